nios_system_switch_debounce: RTL and testbench
==============================================

NIOS_SYSTEM_SWITCH_DEBOUNCE -- requirements
Module: nios_system_switch_debounce

Interface
REQ-001 Parameter WIDTH, default 1: number of independent switch channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clk cycles needed to accept a new level; legal range 2..2^20.
REQ-003 Port clk  input  1: single system clock; all state is rising-edge clocked.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port raw_in  input  WIDTH: raw, asynchronous, bouncing switch levels from the board pins.
REQ-006 Port sw_out  output  WIDTH: debounced levels; drives in_port of the downstream switches PIO slave.
REQ-007 Port change_pulse  output  WIDTH: per-bit one-cycle strobe when the matching sw_out bit toggles.
REQ-008 Port edge_clear  input  WIDTH: per-bit synchronous clear of edge_capture.
REQ-009 Port edge_capture  output  WIDTH: per-bit sticky "level changed" flags.
REQ-010 Port irq  output  1: OR-reduction of edge_capture.

Function
REQ-011 Each raw_in bit SHALL pass through a dedicated 2-flop synchronizer (sync1, then sync2) before any other use.
REQ-012 Each bit SHALL have an independent state machine with states STABLE (sync2 == sw_out) and COUNTING (sync2 != sw_out).
REQ-013 Each bit SHALL have a counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-014 In STABLE, the counter SHALL be held at 0.
REQ-015 In COUNTING, the counter SHALL increment once per cycle.
REQ-016 When the counter equals DEBOUNCE_CYCLES-1 and sync2 still differs, the block SHALL, on that edge: load sync2 into sw_out, clear the counter to 0, and return to STABLE.
REQ-017 If sync2 returns to equal sw_out at any point during COUNTING, the counter SHALL clear to 0 and the state SHALL return to STABLE; sw_out does not change.
REQ-018 Latency: a clean level change on raw_in SHALL appear on sw_out exactly DEBOUNCE_CYCLES+2 rising edges after the edge that first samples it into sync1.
REQ-019 change_pulse[i] SHALL be high for exactly the one cycle following each sw_out[i] update, and low otherwise.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several bits SHALL each be debounced and pulsed separately.
REQ-021 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-022 While reset_n = 0, the following SHALL be asynchronously forced to 0: sync1, sync2, sw_out, counters, state (STABLE), change_pulse, edge_capture and irq.
REQ-023 Reset asserted mid-count SHALL discard the count.
REQ-024 After reset_n deasserts, a raw_in that is held high SHALL be accepted as a normal transition, producing change_pulse and, if compiled in, edge_capture.

Configuration
REQ-025 Macro SWITCH_DEBOUNCE_EDGE_CAPTURE_EN SHALL control the edge-capture feature.
REQ-026 With SWITCH_DEBOUNCE_EDGE_CAPTURE_EN defined:
- edge_capture[i] SHALL set on any sw_out[i] update.
- edge_capture[i] SHALL clear on the cycle after edge_clear[i] = 1.
- A set and a clear in the same cycle SHALL resolve as set.
- irq SHALL be registered, one cycle after edge_capture.
REQ-027 Without the macro, edge_capture and irq SHALL be tied to 0, edge_clear SHALL be ignored, and no capture flops SHALL be inferred; the port list SHALL be unchanged.

Verification
REQ-028 Bench parameters: WIDTH=2, DEBOUNCE_CYCLES=4; all scenarios below use these values.
REQ-029 Clean step: raw_in[0] 0->1 and held -> sw_out[0]=1 exactly 6 edges later; change_pulse[0] high for 1 cycle.
REQ-030 Glitch reject: raw_in[0] high for 3 cycles, then low -> sw_out[0] stays 0 and change_pulse stays 0 throughout.
REQ-031 Bounce: raw_in[1] toggles 1,0,1,0,1 on successive cycles, then holds 1 -> sw_out[1] rises 6 edges after the final 0->1; exactly one change_pulse.
REQ-032 Simultaneous events with macro defined: raw_in=2'b11 held -> sw_out=2'b11, edge_capture=2'b11, irq=1 one cycle later. Then edge_clear=2'b01 -> edge_capture=2'b10, irq stays 1. Then edge_clear=2'b10 in the same cycle as a new sw_out[1] update -> edge_capture[1] stays 1.
REQ-033 Reset mid-count: reset_n low for 1 cycle at count 2 -> all outputs 0 immediately. raw_in still 1 -> sw_out=1 at 6 edges after reset release.
REQ-034 Macro undefined: repeat the simultaneous-events scenario (REQ-032) -> edge_capture=0 and irq=0 throughout; sw_out and change_pulse match REQ-032.

Source files
------------

// File: rtl/nios_system_switch_debounce.sv
// Per-channel switch debouncer: 2-flop synchronizer, STABLE/COUNTING FSM, change strobe.
// Optional sticky edge-capture flags and irq, compiled in with SWITCH_DEBOUNCE_EDGE_CAPTURE_EN.
module nios_system_switch_debounce #(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] change_pulse,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_t;

  // One-cycle "sw_out is being loaded on this edge" flag per channel.
  logic [WIDTH-1:0] load_vec;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic          sync1_reg;
      logic          sync2_reg;
      logic          sw_reg;
      logic          sw_next;
      logic          pulse_reg;
      logic          load;
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      state_t        state_reg;
      state_t        state_next;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // The registered state adds one edge of latency, giving DEBOUNCE_CYCLES+2 overall.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sw_next    = sw_reg;
        load       = 1'b0;
        case (state_reg)
          STABLE: begin
            cnt_next = '0;
            if (sync2_reg != sw_reg) begin
              state_next = COUNTING;
            end
          end
          COUNTING: begin
            if (sync2_reg == sw_reg) begin
              state_next = STABLE;
              cnt_next   = '0;
            end else if (cnt_reg == LAST_COUNT) begin
              state_next = STABLE;
              cnt_next   = '0;
              sw_next    = sync2_reg;
              load       = 1'b1;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          default: begin
            state_next = STABLE;
            cnt_next   = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          state_reg <= STABLE;
          cnt_reg   <= '0;
          sw_reg    <= 1'b0;
          pulse_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          sw_reg    <= sw_next;
          pulse_reg <= load;
        end
      end

      assign sw_out[gi]       = sw_reg;
      assign change_pulse[gi] = pulse_reg;
      assign load_vec[gi]     = load;

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
      logic cap_reg;

      // A new update outranks a clear arriving on the same edge.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          cap_reg <= 1'b0;
        end else if (load) begin
          cap_reg <= 1'b1;
        end else if (edge_clear[gi]) begin
          cap_reg <= 1'b0;
        end
      end

      assign edge_capture[gi] = cap_reg;
`endif
    end
  endgenerate

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
  logic irq_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_reg <= 1'b0;
    end else begin
      irq_reg <= |edge_capture;
    end
  end

  assign irq = irq_reg;
`else
  logic unused_edge_inputs;

  assign edge_capture       = '0;
  assign irq                = 1'b0;
  assign unused_edge_inputs = ^{edge_clear, load_vec};
`endif

endmodule

// File: tb/tb_nios_system_switch_debounce.sv
// Directed bench for nios_system_switch_debounce with WIDTH=2, DEBOUNCE_CYCLES=4.
// Expected edge_capture/irq follow whether SWITCH_DEBOUNCE_EDGE_CAPTURE_EN is defined.
module tb_nios_system_switch_debounce;

`ifdef SWITCH_DEBOUNCE_EDGE_CAPTURE_EN
  localparam bit EC_EN = 1'b1;
`else
  localparam bit EC_EN = 1'b0;
`endif

  // raw_in change set just after an edge reaches sw_out on the 7th following edge.
  localparam int LAT = 7;

  logic       clk;
  logic       reset_n;
  logic [1:0] raw_in;
  logic [1:0] sw_out;
  logic [1:0] change_pulse;
  logic [1:0] edge_clear;
  logic [1:0] edge_capture;
  logic       irq;

  int checks   = 0;
  int failures = 0;
  int pulses;

  nios_system_switch_debounce #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_in(raw_in),
    .sw_out(sw_out),
    .change_pulse(change_pulse),
    .edge_clear(edge_clear),
    .edge_capture(edge_capture),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] ec(input logic [1:0] v);
    return EC_EN ? v : 2'b00;
  endfunction

  task automatic do_reset();
    reset_n    = 1'b0;
    raw_in     = 2'b00;
    edge_clear = 2'b00;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b1;
    raw_in     = 2'b00;
    edge_clear = 2'b00;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_sw", sw_out, 2'b00);
    chk("rst_cp", change_pulse, 2'b00);
    chk("rst_ec", edge_capture, 2'b00);
    chk("rst_irq", irq, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_sw", sw_out, 2'b00);

    // Clean step on channel 0
    raw_in = 2'b01;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k < LAT) begin
        chk("clean_wait_sw", sw_out, 2'b00);
        chk("clean_wait_cp", change_pulse, 2'b00);
      end
    end
    chk("clean_sw", sw_out, 2'b01);
    chk("clean_cp", change_pulse, 2'b01);
    chk("clean_ec", edge_capture, ec(2'b01));
    chk("clean_irq_lag", irq, 1'b0);
    step();
    chk("clean_cp_drop", change_pulse, 2'b00);
    chk("clean_sw_hold", sw_out, 2'b01);
    chk("clean_irq", irq, EC_EN);
    edge_clear = 2'b01;
    step();
    edge_clear = 2'b00;
    chk("clean_ec_clr", edge_capture, 2'b00);
    step();
    chk("clean_irq_clr", irq, 1'b0);

    // Glitch shorter than the debounce window
    do_reset();
    raw_in = 2'b01;
    repeat (3) step();
    raw_in = 2'b00;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("glitch_sw", sw_out, 2'b00);
      chk("glitch_cp", change_pulse, 2'b00);
    end

    // Bounce on channel 1 then settle high
    do_reset();
    pulses = 0;
    raw_in = 2'b10; step(); pulses += int'(change_pulse[1]);
    raw_in = 2'b00; step(); pulses += int'(change_pulse[1]);
    raw_in = 2'b10; step(); pulses += int'(change_pulse[1]);
    raw_in = 2'b00; step(); pulses += int'(change_pulse[1]);
    raw_in = 2'b10;
    for (int k = 1; k <= LAT; k++) begin
      step();
      pulses += int'(change_pulse[1]);
      if (k < LAT) chk("bounce_wait_sw", sw_out, 2'b00);
    end
    chk("bounce_sw", sw_out, 2'b10);
    chk("bounce_cp", change_pulse, 2'b10);
    repeat (4) begin
      step();
      pulses += int'(change_pulse[1]);
    end
    chk("bounce_pulses", pulses, 1);

    // Simultaneous transitions, clear, and set-beats-clear
    do_reset();
    raw_in = 2'b11;
    repeat (LAT - 1) step();
    chk("simul_wait_sw", sw_out, 2'b00);
    step();
    chk("simul_sw", sw_out, 2'b11);
    chk("simul_cp", change_pulse, 2'b11);
    chk("simul_ec", edge_capture, ec(2'b11));
    chk("simul_irq_lag", irq, 1'b0);
    step();
    chk("simul_irq", irq, EC_EN);
    chk("simul_cp_drop", change_pulse, 2'b00);
    edge_clear = 2'b01;
    step();
    edge_clear = 2'b00;
    chk("simul_ec_clr0", edge_capture, ec(2'b10));
    chk("simul_irq_hold", irq, EC_EN);
    step();
    chk("simul_irq_hold2", irq, EC_EN);
    raw_in = 2'b01;
    repeat (LAT - 1) step();
    edge_clear = 2'b10;
    step();
    edge_clear = 2'b00;
    chk("setwin_sw", sw_out, 2'b01);
    chk("setwin_cp", change_pulse, 2'b10);
    chk("setwin_ec", edge_capture, ec(2'b10));
    step();
    chk("setwin_ec_hold", edge_capture, ec(2'b10));
    chk("setwin_irq", irq, EC_EN);
    edge_clear = 2'b10;
    step();
    edge_clear = 2'b00;
    chk("clr1_ec", edge_capture, 2'b00);
    step();
    chk("clr1_irq", irq, 1'b0);

    // Reset mid-count discards the count
    do_reset();
    raw_in = 2'b10;
    repeat (LAT) step();
    chk("midrst_pre_sw", sw_out, 2'b10);
    raw_in = 2'b11;
    repeat (5) step();
    chk("midrst_count_sw", sw_out, 2'b10);
    reset_n = 1'b0;
    #1;
    chk("midrst_sw", sw_out, 2'b00);
    chk("midrst_cp", change_pulse, 2'b00);
    chk("midrst_ec", edge_capture, 2'b00);
    chk("midrst_irq", irq, 1'b0);
    step();
    reset_n = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      if (k < LAT) chk("midrst_wait_sw", sw_out, 2'b00);
    end
    chk("midrst_re_sw", sw_out, 2'b11);
    chk("midrst_re_cp", change_pulse, 2'b11);
    chk("midrst_re_ec", edge_capture, ec(2'b11));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
